// File: rtl/kstep_spi_cmd_pkg.sv
// Shared types and constants for the stepper SPI command front end.
// Frame layout, status bit positions and the frame FSM states.
package kstep_pkg;

    localparam int ADDR_W       = 7;
    localparam int CMD_WR_BIT   = 7;
    localparam int STAT_OVERRUN = 0;
    localparam int STAT_PENDING = 1;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } state_e;

    function automatic logic [7:0] status_byte(
        input logic pending,
        input logic ovr
    );
        logic [7:0] s;
        s = '0;
        s[STAT_PENDING] = pending;
        s[STAT_OVERRUN] = ovr;
        return s;
    endfunction

endpackage

// File: rtl/kstep_spi_cmd_if.sv
// Command/register side of the SPI front end: write command
// handshake, read request/response and the sticky overrun flag.
interface kstep_spi_cmd_if #(
    parameter int DATA_BYTES = 4
);
    import kstep_pkg::*;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_W-1:0]       cmd_addr;
    logic [8*DATA_BYTES-1:0] cmd_data;
    logic                    rd_strobe;
    logic [ADDR_W-1:0]       rd_addr;
    logic [8*DATA_BYTES-1:0] rd_data;
    logic                    overrun;

    modport master (
        output cmd_valid,
        output cmd_addr,
        output cmd_data,
        output rd_strobe,
        output rd_addr,
        output overrun,
        input  cmd_ready,
        input  rd_data
    );

    modport slave (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_data,
        input  rd_strobe,
        input  rd_addr,
        input  overrun,
        output cmd_ready,
        output rd_data
    );

endinterface

// File: rtl/kstep_spi_cmd_sync.sv
// Synchronisers for the SPI pins: edge pulses for cs and sclk,
// plain synchronised level for mosi.
module kstep_spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_i,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic cs_rise_o,
    output logic cs_fall_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic mosi_o
);

    logic [STAGES-1:0] cs_q;
    logic [STAGES-1:0] sclk_q;
    logic [STAGES-1:0] mosi_q;
    logic              cs_e_q;
    logic              sclk_e_q;

    // cs resets to "selected" so a frame already in flight at reset
    // release produces no fall edge and is ignored until cs cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q     <= '0;
            sclk_q   <= '0;
            mosi_q   <= '0;
            cs_e_q   <= 1'b0;
            sclk_e_q <= 1'b0;
        end else begin
            cs_q     <= {cs_q[STAGES-2:0], cs_i};
            sclk_q   <= {sclk_q[STAGES-2:0], sclk_i};
            mosi_q   <= {mosi_q[STAGES-2:0], mosi_i};
            cs_e_q   <= cs_q[STAGES-1];
            sclk_e_q <= sclk_q[STAGES-1];
        end
    end

    assign cs_rise_o   =  cs_q[STAGES-1] & ~cs_e_q;
    assign cs_fall_o   = ~cs_q[STAGES-1] &  cs_e_q;
    assign sclk_rise_o =  sclk_q[STAGES-1] & ~sclk_e_q;
    assign sclk_fall_o = ~sclk_q[STAGES-1] &  sclk_e_q;
    assign mosi_o      =  mosi_q[STAGES-1];

endmodule

// File: rtl/kstep_spi_cmd.sv
// SPI mode-0 slave that turns fixed-length frames into scheduler
// write commands or register reads shifted back out on MISO.
module kstep_spi_cmd
    import kstep_pkg::*;
#(
    parameter int DATA_BYTES  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_cs,
    input  logic spi_sclk,
    input  logic spi_mosi,
    output logic spi_miso,
    kstep_spi_cmd_if.master bus
);

    localparam int W   = 8 * DATA_BYTES;
    localparam int BCW = $clog2(DATA_BYTES + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(DATA_BYTES - 1);
    localparam logic [BCW-1:0] ONE_BYTE  = BCW'(1);

    logic cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_s;

    kstep_spi_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_i       (spi_cs),
        .sclk_i     (spi_sclk),
        .mosi_i     (spi_mosi),
        .cs_rise_o  (cs_rise),
        .cs_fall_o  (cs_fall),
        .sclk_rise_o(sclk_rise),
        .sclk_fall_o(sclk_fall),
        .mosi_o     (mosi_s)
    );

    state_e            state_q, state_d;
    logic [2:0]        bit_q, bit_d;
    logic [BCW-1:0]    byte_q, byte_d;
    logic [W-2:0]      pay_q, pay_d;
    logic [W-1:0]      tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_strobe_q, rd_strobe_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [W-1:0]      cmd_data_q, cmd_data_d;
    logic              ovr_q, ovr_d;

    logic [7:0] stat;
    logic [7:0] byte_in;
    logic       accept;
    logic       last_bit;

    assign stat     = status_byte(cmd_valid_q, ovr_q);
    assign byte_in  = {pay_q[6:0], mosi_s};
    assign accept   = cmd_valid_q & bus.cmd_ready;
    assign last_bit = (bit_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        pay_d       = pay_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        rd_strobe_d = 1'b0;
        rd_addr_d   = rd_addr_q;
        cmd_valid_d = cmd_valid_q & ~accept;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        ovr_d       = ovr_q;

        // Read word is captured at the end of the strobe cycle.
        if (rd_strobe_q)
            tx_d = bus.rd_data;

        if (cs_rise) begin
            state_d = IDLE;
            miso_d  = 1'b0;
            bit_d   = '0;
            byte_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    miso_d = 1'b0;
                    bit_d  = '0;
                    byte_d = '0;
                    if (cs_fall) begin
                        tx_d    = {stat[6:0], {(W-7){1'b0}}};
                        miso_d  = stat[7];
                        state_d = CMD;
                    end
                end
                CMD: begin
                    if (sclk_rise && !cs_fall) begin
                        pay_d = {pay_q[W-3:0], mosi_s};
                        bit_d = bit_q + 3'd1;
                        if (last_bit) begin
                            wr_d    = byte_in[CMD_WR_BIT];
                            addr_d  = byte_in[ADDR_W-1:0];
                            ovr_d   = 1'b0;
                            state_d = DATA;
                            if (!byte_in[CMD_WR_BIT]) begin
                                rd_addr_d   = byte_in[ADDR_W-1:0];
                                rd_strobe_d = 1'b1;
                            end else begin
                                tx_d = '0;
                            end
                        end
                    end
                    if (sclk_fall && !cs_fall) begin
                        miso_d = tx_q[W-1];
                        tx_d   = {tx_q[W-2:0], 1'b0};
                    end
                end
                DATA: begin
                    if (sclk_rise && !cs_fall) begin
                        pay_d = {pay_q[W-3:0], mosi_s};
                        bit_d = bit_q + 3'd1;
                        if (last_bit) begin
                            byte_d = byte_q + ONE_BYTE;
                            if (byte_q == LAST_BYTE) begin
                                state_d = DONE;
                                miso_d  = 1'b0;
                                if (wr_q) begin
                                    if (!cmd_valid_q || accept) begin
                                        cmd_valid_d = 1'b1;
                                        cmd_addr_d  = addr_q;
                                        cmd_data_d  = {pay_q, mosi_s};
                                    end else begin
                                        ovr_d = 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    if (sclk_fall && !cs_fall && state_d != DONE) begin
                        miso_d = tx_q[W-1];
                        tx_d   = {tx_q[W-2:0], 1'b0};
                    end
                end
                DONE: begin
                    miso_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            byte_q      <= '0;
            pay_q       <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            rd_strobe_q <= 1'b0;
            rd_addr_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            pay_q       <= pay_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            rd_strobe_q <= rd_strobe_d;
            rd_addr_q   <= rd_addr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            ovr_q       <= ovr_d;
        end
    end

    assign spi_miso      = miso_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_addr  = cmd_addr_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.rd_strobe = rd_strobe_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_kstep_spi_cmd.sv
// Bench for kstep_spi_cmd: SPI master driver, frame-level model
// and a scoreboard monitor on the command/read side.
module tb_kstep_spi_cmd;
    import kstep_pkg::*;

    localparam int DB = 4;

    typedef struct packed {
        logic [6:0]  a;
        logic [31:0] d;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_cs = 1'b1;
    logic spi_sclk = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_miso;

    kstep_spi_cmd_if #(.DATA_BYTES(DB)) bus ();

    kstep_spi_cmd #(
        .DATA_BYTES (DB),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .spi_cs  (spi_cs),
        .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    cmd_t       exp_cmd[$];
    logic [6:0] exp_rd[$];
    bit         m_pend = 0;
    bit         m_ovr = 0;
    logic [31:0] rd_word = '0;

    logic [7:0] mb[0:7];
    logic [7:0] sb[0:7];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_miso", spi_miso, 0);
        chk("rst_cmd_valid", bus.cmd_valid, 0);
        chk("rst_cmd_addr", bus.cmd_addr, 0);
        chk("rst_cmd_data", bus.cmd_data, 0);
        chk("rst_rd_strobe", bus.rd_strobe, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_overrun", bus.overrun, 0);
    endtask

    // Scoreboard monitor: every cycle a command is presented it must
    // match the oldest expected one; it retires on acceptance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cmd_valid) begin
                if (exp_cmd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_unexpected act=%0h/%0h exp=none",
                             bus.cmd_addr, bus.cmd_data);
                end else begin
                    chk("cmd_addr", bus.cmd_addr, exp_cmd[0].a);
                    chk("cmd_data", bus.cmd_data, exp_cmd[0].d);
                    if (bus.cmd_ready)
                        void'(exp_cmd.pop_front());
                end
            end
            if (bus.rd_strobe) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected act=%0h exp=none",
                             bus.rd_addr);
                end else begin
                    chk("rd_addr", bus.rd_addr, exp_rd.pop_front());
                end
            end
        end
    end

    task automatic spi_xfer(input int nbytes, input int rst_bit);
        spi_cs = 1'b0;
        tick(8);
        for (int i = 0; i < nbytes * 8; i++) begin
            spi_mosi = mb[i/8][7-i%8];
            if (i == rst_bit) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outputs();
                tick(3);
                rst_n = 1'b1;
            end
            tick(8);
            sb[i/8][7-i%8] = spi_miso;
            spi_sclk = 1'b1;
            tick(8);
            spi_sclk = 1'b0;
        end
        tick(8);
        spi_cs = 1'b1;
        tick(8);
    endtask

    task automatic set_ready(input bit r);
        bus.cmd_ready = r;
        if (r)
            m_pend = 0;
        tick(4);
    endtask

    // Frame-level reference: status byte, MISO bytes and command fate
    // follow from the frame length, wr bit and the pending state.
    task automatic frame(input bit wr, input logic [6:0] addr,
                         input logic [31:0] data, input int nbytes,
                         input int rst_bit);
        logic [7:0] exp_mi[0:7];
        bit complete;
        for (int k = 0; k < 8; k++)
            exp_mi[k] = 8'h00;
        exp_mi[0] = {6'b0, m_pend, m_ovr};
        if (!wr)
            for (int k = 0; k < DB; k++)
                exp_mi[1+k] = rd_word[31-8*k -: 8];
        mb[0] = {wr, addr};
        for (int k = 0; k < DB; k++)
            mb[1+k] = data[31-8*k -: 8];
        for (int k = 1 + DB; k < 8; k++)
            mb[k] = 8'($urandom);
        bus.rd_data = rd_word;
        complete = (nbytes >= 1 + DB) && (rst_bit < 0);
        if (rst_bit < 0) begin
            if (nbytes >= 1) begin
                m_ovr = 0;
                if (!wr)
                    exp_rd.push_back(addr);
            end
            if (complete && wr) begin
                if (m_pend && !bus.cmd_ready) begin
                    m_ovr = 1;
                end else begin
                    exp_cmd.push_back(cmd_t'{a: addr, d: data});
                    m_pend = !bus.cmd_ready;
                end
            end
        end
        spi_xfer(nbytes, rst_bit);
        if (rst_bit >= 0) begin
            exp_cmd.delete();
            exp_rd.delete();
            m_pend = 0;
            m_ovr = 0;
        end
        for (int b = 0; b < nbytes; b++)
            if (rst_bit < 0 || (b + 1) * 8 <= rst_bit)
                chk($sformatf("miso_byte%0d", b), sb[b], exp_mi[b]);
        chk("overrun", bus.overrun, m_ovr);
    endtask

    initial begin
        bus.cmd_ready = 1'b0;
        bus.rd_data = '0;
        tick(3);
        chk_reset_outputs();
        rst_n = 1'b1;
        tick(5);

        set_ready(1);
        frame(1, 7'h05, 32'h12345678, 5, -1);

        rd_word = 32'hDEADBEEF;
        frame(0, 7'h03, 32'h0, 5, -1);

        set_ready(0);
        frame(1, 7'h11, 32'hA5A5_0001, 5, -1);
        frame(1, 7'h22, 32'h5A5A_0002, 5, -1);
        chk("held_valid", bus.cmd_valid, 1);
        rd_word = 32'h0BAD_F00D;
        frame(0, 7'h07, 32'h0, 5, -1);
        set_ready(1);

        frame(1, 7'h0A, 32'hCAFE_BABE, 3, -1);
        frame(1, 7'h0B, 32'h0123_4567, 5, -1);

        frame(1, 7'h44, 32'h8765_4321, 5, 8 + 12);
        frame(1, 7'h45, 32'hFEDC_BA98, 5, -1);

        frame(1, 7'h66, 32'h1357_9BDF, 6, -1);

        for (int n = 0; n < 24; n++) begin
            int r;
            set_ready(($urandom % 3) != 0);
            rd_word = $urandom;
            r = $urandom % 8;
            frame($urandom % 2, 7'($urandom), $urandom,
                  (r < 5) ? 5 : (r == 5) ? 6 : 1 + $urandom % 4, -1);
        end

        set_ready(1);
        tick(20);
        chk("cmd_queue_empty", exp_cmd.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kstep_spi_cmd.md
Name: kstep_spi_cmd

Overview:
- SPI mode-0 slave front end for the stepper pulse scheduler; sits directly upstream of the scheduler's command/register interface.
- Oversamples `spi_cs`/`spi_sclk`/`spi_mosi` in the `clk` domain and assembles fixed-length frames.
- Write frames become a valid/ready command to the scheduler; read frames fetch a register word and shift it out on `spi_miso`.

Parameters:
- DATA_BYTES, 4, payload bytes per frame; `cmd_data`/`rd_data` width = 8*DATA_BYTES.
- SYNC_STAGES, 2, flop stages on each SPI input before edge detection; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- spi_cs  in  1  chip select, active low.
- spi_sclk  in  1  SPI clock, idle low.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first.
- cmd_valid  out  1  write command pending.
- cmd_ready  in  1  downstream accepts command.
- cmd_addr  out  7  write register address.
- cmd_data  out  8*DATA_BYTES  write payload; byte 1 of the frame is the MSB.
- rd_strobe  out  1  one-cycle read request.
- rd_addr  out  7  read register address.
- rd_data  in  8*DATA_BYTES  read word; captured on the clk edge ending the `rd_strobe` cycle.
- overrun  out  1  sticky flag: a completed write frame was dropped.

Behaviour:
- Reset values: `spi_miso`=0, `cmd_valid`=0, `cmd_addr`=0, `cmd_data`=0, `rd_strobe`=0, `rd_addr`=0, `overrun`=0; FSM=IDLE.
- Reset is asynchronous and may occur mid-frame; the partial frame is discarded.
- Synchronisation:
  - Each input passes SYNC_STAGES flops, then one edge-detect flop.
  - SPI events act 3 clk after the pin edge (SYNC_STAGES=2).
  - Requirement: sclk ≤ clk/8; cs setup/hold to sclk ≥ 4 clk.
- Frame format: byte 0 = {wr, addr[6:0]}, then DATA_BYTES payload bytes.
- MOSI is sampled on synced sclk rise; MISO updates on synced sclk fall.
- FSM IDLE:
  - Entered while synced cs is high; `spi_miso` driven 0; bit and byte counters cleared.
  - On cs fall: load status byte {6'b0, cmd_valid, overrun} into the TX shift register, drive its MSB, go to CMD.
- FSM CMD:
  - Shift 8 bits in.
  - On the 8th rise, latch wr/addr.
  - If wr=0: `rd_addr`=addr, pulse `rd_strobe` the next cycle, load TX shift with `rd_data` at the end of that cycle.
  - If wr=1: load TX shift with zeros.
  - `overrun` clears at the 8th rise, since status has been reported. A set event in the same cycle wins.
  - Go to DATA.
- FSM DATA:
  - Shift bytes into a payload register.
  - TX shifts one bit per falling edge.
  - After DATA_BYTES bytes, go to DONE.
  - If wr=1 at that point:
    - If `cmd_valid`=0: latch `cmd_addr`/`cmd_data`, set `cmd_valid` the next cycle.
    - If `cmd_valid`=1: drop the frame and set `overrun`.
- FSM DONE: extra sclk pulses are ignored; `spi_miso`=0; stay until cs rises.
- cs rise in any state: go to IDLE the same cycle it is detected. A partial frame produces no command and no overrun; `rd_strobe` already issued is not retracted.
- Handshake:
  - `cmd_valid` stays high and `cmd_addr`/`cmd_data` stay stable until a cycle with `cmd_valid` & `cmd_ready`; `cmd_valid` deasserts on the following edge.
  - `cmd_ready` may be high before valid.
  - Acceptance and a new frame completion in the same cycle: accept the old command, latch the new one, `cmd_valid` stays 1, no overrun.
- sclk and cs edges detected in the same cycle: the cs edge takes priority; the sclk edge is ignored.

Decomposition:
- Shared package kstep_pkg:
  - ADDR_W=7, CMD_WR_BIT=7.
  - Status bit indices: STAT_OVERRUN=0, STAT_PENDING=1.
  - FSM state enum {IDLE, CMD, DATA, DONE}.
- One sub-module, kstep_spi_sync: parameterised synchroniser plus rise/fall pulse detector; instantiated for cs and sclk, with a plain synchronised output for mosi.

Test Plan:
- Write frame 0x85, 0x12345678 with `cmd_ready`=1 → `cmd_valid` pulses 1 cycle, `cmd_addr`=0x05, `cmd_data`=0x12345678; MISO byte 0 = 0x00.
- Read frame 0x03 with `rd_data`=0xDEADBEEF → one `rd_strobe`, `rd_addr`=0x03; MISO bytes 1-4 = DE AD BE EF.
- `cmd_ready`=0, two write frames → first command held stable, second dropped, `overrun`=1; next frame's status byte = 0x03, `overrun`=0 after its byte 0.
- cs raised after 2 payload bytes of a write → no `cmd_valid`, `overrun`=0; the following full frame executes normally.
- Assert `rst_n` low mid-byte during DATA → all outputs at reset values immediately; next frame decodes correctly.
- Extra byte after a full write frame → still exactly one command; `spi_miso`=0 during the extra byte.
